// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and a one-entry key holding register
//
// Purpose: strobes one keypad column at a time, debounces a press and a
// release on the captured row, and presents each accepted key once through
// a valid/ready holding register. A key that arrives while the register
// is still full is dropped, and the sticky overrun flag records the drop.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   row_n      keypad rows, active-low, asynchronous to clk
//   col_n      column strobes, active-low, exactly one bit low
//   key_code   accepted key, row_index*4 + col_index
//   key_valid  key_code holds an unconsumed key
//   key_ready  consumer takes key_code when key_valid & key_ready
//   overrun    sticky: a debounced key was dropped

module keypad_scan #(
  parameter int SCAN_DIV = 6250,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int              SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]      DB_MAX    = 8'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    row_meta, row_sync;
  logic [SW-1:0] slot;
  logic [1:0]    col_idx;
  logic [1:0]    cap_row;
  logic [7:0]    db_cnt, db_nxt, db_inc;
  logic          tick, any_low, cap_low, accept;
  logic [1:0]    low_row;
  logic          emit, col_adv, cap_load;

  assign tick    = (slot == SLOT_LAST);
  assign any_low = ~&row_sync;
  assign cap_low = ~row_sync[cap_row];
  assign accept  = key_valid & key_ready;
  assign col_n   = ~(4'b0001 << col_idx);
  // Saturating increment; the compare against DB_MAX decides the transition.
  assign db_inc  = (db_cnt == DB_MAX) ? db_cnt : db_cnt + 8'd1;

  // Lowest-index low row wins when several rows are pulled low together.
  always_comb begin
    low_row = 2'd0;
    if (!row_sync[0])      low_row = 2'd0;
    else if (!row_sync[1]) low_row = 2'd1;
    else if (!row_sync[2]) low_row = 2'd2;
    else if (!row_sync[3]) low_row = 2'd3;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick && any_low) state_nxt = PRESS;
      PRESS:   if (tick) begin
                 if (!cap_low)              state_nxt = IDLE;
                 else if (db_inc == DB_MAX) state_nxt = HELD;
               end
      HELD:    if (tick && !cap_low && db_inc == DB_MAX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath control. Every exit clears the debounce count so the
  // entered state starts from zero (or from its first sample, for PRESS).
  always_comb begin
    emit     = 1'b0;
    col_adv  = 1'b0;
    cap_load = 1'b0;
    db_nxt   = db_cnt;
    case (state)
      IDLE: if (tick) begin
        if (any_low) begin
          cap_load = 1'b1;
          db_nxt   = 8'd1;
        end else begin
          col_adv = 1'b1;
        end
      end
      PRESS: if (tick) begin
        if (!cap_low) begin
          col_adv = 1'b1;
          db_nxt  = 8'd0;
        end else if (db_inc == DB_MAX) begin
          emit   = 1'b1;
          db_nxt = 8'd0;
        end else begin
          db_nxt = db_inc;
        end
      end
      HELD: if (tick) begin
        if (cap_low) begin
          db_nxt = 8'd0;
        end else if (db_inc == DB_MAX) begin
          col_adv = 1'b1;
          db_nxt  = 8'd0;
        end else begin
          db_nxt = db_inc;
        end
      end
      default: db_nxt = 8'd0;
    endcase
  end

  // Synchronizer, slot counter, scan column and debounce datapath.
  // The column index stays frozen outside IDLE, so it doubles as the
  // captured column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      slot     <= '0;
      col_idx  <= 2'd0;
      cap_row  <= 2'd0;
      db_cnt   <= 8'd0;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      slot     <= tick ? '0 : slot + 1'b1;
      db_cnt   <= db_nxt;
      if (col_adv)  col_idx <= col_idx + 2'd1;
      if (cap_load) cap_row <= low_row;
    end
  end

  // Key holding register. A new key replaces the held one only when the
  // register is empty or being consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (emit) begin
      if (!key_valid || accept) begin
        key_code  <= {cap_row, col_idx};
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3)
//
// Inputs change on the falling edge right after a tick edge, so each
// cyc(4) step lands exactly one scan tick later.

module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n = 4'hF;
  logic       key_ready = 1'b0;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    row_n = 4'hF;
    key_ready = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", col_n); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%h exp=0", key_code); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL pre_first_tick_col got=%b exp=1110", col_n); end
    cyc(1);
    checks++; if (col_n !== 4'b1101) begin failures++; $display("FAIL first_tick_col got=%b exp=1101", col_n); end
  endtask

  task automatic test_press();
    do_reset();
    cyc(8);
    checks++; if (col_n !== 4'b1011) begin failures++; $display("FAIL press_reach_col got=%b exp=1011", col_n); end
    row_n = 4'b1011;
    cyc(4);
    checks++; if (col_n !== 4'b1011) begin failures++; $display("FAIL press_frozen_col got=%b exp=1011", col_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_valid_t1 got=%b exp=0", key_valid); end
    cyc(4);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_valid_t2 got=%b exp=0", key_valid); end
    cyc(4);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press_valid_t3 got=%b exp=1", key_valid); end
    checks++; if (key_code !== 4'hA) begin failures++; $display("FAIL press_code got=%h exp=a", key_code); end
    key_ready = 1'b1;
    cyc(1);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_handshake got=%b exp=0", key_valid); end
    key_ready = 1'b0;
    cyc(3);
    cyc(8);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press_no_repeat got=%b exp=0", key_valid); end
    row_n = 4'hF;
    cyc(8);
    checks++; if (col_n !== 4'b1011) begin failures++; $display("FAIL release_hold_col got=%b exp=1011", col_n); end
    cyc(4);
    checks++; if (col_n !== 4'b0111) begin failures++; $display("FAIL release_adv_col got=%b exp=0111", col_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", key_valid); end
  endtask

  task automatic test_bounce();
    do_reset();
    row_n = 4'b1101;
    cyc(4);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL bounce_frozen_col got=%b exp=1110", col_n); end
    row_n = 4'hF;
    cyc(4);
    checks++; if (col_n !== 4'b1101) begin failures++; $display("FAIL bounce_adv_col got=%b exp=1101", col_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid got=%b exp=0", key_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bounce_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    row_n = 4'b1110;
    cyc(12);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL ovr_first_code got=%h exp=0", key_code); end
    row_n = 4'hF;
    cyc(12);
    checks++; if (col_n !== 4'b1101) begin failures++; $display("FAIL ovr_release_col got=%b exp=1101", col_n); end
    cyc(8);
    checks++; if (col_n !== 4'b0111) begin failures++; $display("FAIL ovr_col3 got=%b exp=0111", col_n); end
    row_n = 4'b0111;
    cyc(12);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL ovr_code_kept got=%h exp=0", key_code); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", key_valid); end
    key_ready = 1'b1;
    cyc(1);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL ovr_hs_valid got=%b exp=0", key_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_hs_clear got=%b exp=0", overrun); end
    key_ready = 1'b0;
  endtask

  task automatic test_release_bounce();
    do_reset();
    row_n = 4'b1110;
    cyc(12);
    key_ready = 1'b1;
    cyc(1);
    key_ready = 1'b0;
    cyc(3);
    row_n = 4'hF;
    cyc(8);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rb_high2_col got=%b exp=1110", col_n); end
    row_n = 4'b1110;
    cyc(4);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rb_low_col got=%b exp=1110", col_n); end
    row_n = 4'hF;
    cyc(8);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rb_high_again2_col got=%b exp=1110", col_n); end
    cyc(4);
    checks++; if (col_n !== 4'b1101) begin failures++; $display("FAIL rb_idle_col got=%b exp=1101", col_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rb_valid got=%b exp=0", key_valid); end
  endtask

  task automatic test_reset_in_held();
    do_reset();
    cyc(4);
    row_n = 4'b1110;
    cyc(12);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL rh_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== 4'd1) begin failures++; $display("FAIL rh_code got=%h exp=1", key_code); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rh_async_col got=%b exp=1110", col_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rh_async_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL rh_async_code got=%h exp=0", key_code); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rh_async_overrun got=%b exp=0", overrun); end
    row_n = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rh_pre_tick_col got=%b exp=1110", col_n); end
    cyc(1);
    checks++; if (col_n !== 4'b1101) begin failures++; $display("FAIL rh_tick_col got=%b exp=1101", col_n); end
  endtask

  task automatic test_two_rows();
    do_reset();
    cyc(8);
    row_n = 4'b0101;
    cyc(12);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL two_rows_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== 4'd6) begin failures++; $display("FAIL two_rows_code got=%h exp=6", key_code); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_overrun();
    test_release_bounce();
    test_reset_in_held();
    test_two_rows();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
